// File: rtl/enclave_monitor_array.sv
// Purpose : Per-enclave copy-handshake monitor. The reset of each enclave is
//           released only after a completed image copy. Each channel also has
//           a copy watchdog and sticky protocol-violation faults that raise irq.
// Latency : 1 cycle from an input sampled at a rising edge to outputs
//           (Moore decode of the state register); irq trails fault by 1 more cycle.
// Backpressure: none; inputs are level-sampled every cycle and never stalled.
//
// Ports:
//   aclk        clock, all logic on the rising edge
//   nreset      synchronous active-low reset
//   strt_cpy    per-channel copy request / session-active level
//   done_cpy    per-channel copy-complete indication
//   fault_clr   per-channel fault acknowledge
//   done        per-channel: copy complete, enclave running
//   rst_enclave per-channel enclave reset, active-high
//   fault       per-channel sticky fault
//   irq         registered OR of all fault bits

module enclave_monitor_array #(
    parameter int NUM_ENCL = 4,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 1000
) (
    input  logic                aclk,
    input  logic                nreset,
    input  logic [NUM_ENCL-1:0] strt_cpy,
    input  logic [NUM_ENCL-1:0] done_cpy,
    input  logic [NUM_ENCL-1:0] fault_clr,
    output logic [NUM_ENCL-1:0] done,
    output logic [NUM_ENCL-1:0] rst_enclave,
    output logic [NUM_ENCL-1:0] fault,
    output logic                irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COPY  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // TIMEOUT == 0 turns the watchdog off entirely; the counter then stays at 0.
    localparam logic             WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT != 0) ? (TIMEOUT - 1) : 0);

    state_t           state_q [NUM_ENCL];
    state_t           state_d [NUM_ENCL];
    logic [CNT_W-1:0] cnt_q   [NUM_ENCL];
    logic [CNT_W-1:0] cnt_d   [NUM_ENCL];

    always_ff @(posedge aclk) begin
        if (!nreset) begin
            for (int i = 0; i < NUM_ENCL; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENCL; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next state. The counter defaults to 0 so it is cleared in every non-COPY
    // state and on every entry to COPY; it only advances while staying in COPY.
    always_comb begin
        for (int i = 0; i < NUM_ENCL; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            case (state_q[i])
                S_IDLE: begin
                    // A completion with no session open is a violation, even
                    // if a request arrives in the same cycle.
                    if (done_cpy[i]) begin
                        state_d[i] = S_FAULT;
                    end else if (strt_cpy[i]) begin
                        state_d[i] = S_COPY;
                    end
                end
                S_COPY: begin
                    // Completion beats both abort and watchdog expiry.
                    if (done_cpy[i]) begin
                        state_d[i] = S_RUN;
                    end else if (!strt_cpy[i]) begin
                        state_d[i] = S_IDLE;
                    end else if (WDOG_EN && (cnt_q[i] == CNT_LAST)) begin
                        state_d[i] = S_FAULT;
                    end else if (WDOG_EN) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!strt_cpy[i]) begin
                        state_d[i] = S_IDLE;
                    end
                end
                S_FAULT: begin
                    // Acknowledge only counts once the requester has let go,
                    // so a stuck request cannot silently restart a session.
                    if (fault_clr[i] && !strt_cpy[i]) begin
                        state_d[i] = S_IDLE;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        done        = '0;
        rst_enclave = '1;
        fault       = '0;
        for (int i = 0; i < NUM_ENCL; i++) begin
            done[i]        = (state_q[i] == S_RUN);
            rst_enclave[i] = (state_q[i] != S_RUN);
            fault[i]       = (state_q[i] == S_FAULT);
        end
    end

    always_ff @(posedge aclk) begin
        if (!nreset) begin
            irq <= 1'b0;
        end else begin
            irq <= |fault;
        end
    end

endmodule

// File: tb/tb_enclave_monitor_array.sv
// Purpose : Directed bench for enclave_monitor_array; a 4-channel TIMEOUT=8
//           instance and a 1-channel instance with the watchdog disabled.
// Checking: stimulus queues expected values tagged with the edge after which
//           they must hold; an independent monitor pops and compares them.

module tb_enclave_monitor_array;

    logic       aclk = 1'b0;
    logic       nreset;

    logic [3:0] strt_a, done_cpy_a, fault_clr_a;
    logic [3:0] done_a, rst_a, fault_a;
    logic       irq_a;

    logic [0:0] strt_b, done_cpy_b, fault_clr_b;
    logic [0:0] done_b, rst_b, fault_b;
    logic       irq_b;

    enclave_monitor_array #(.NUM_ENCL(4), .CNT_W(16), .TIMEOUT(8)) dut_a (
        .aclk        (aclk),
        .nreset      (nreset),
        .strt_cpy    (strt_a),
        .done_cpy    (done_cpy_a),
        .fault_clr   (fault_clr_a),
        .done        (done_a),
        .rst_enclave (rst_a),
        .fault       (fault_a),
        .irq         (irq_a)
    );

    enclave_monitor_array #(.NUM_ENCL(1), .CNT_W(16), .TIMEOUT(0)) dut_b (
        .aclk        (aclk),
        .nreset      (nreset),
        .strt_cpy    (strt_b),
        .done_cpy    (done_cpy_b),
        .fault_clr   (fault_clr_b),
        .done        (done_b),
        .rst_enclave (rst_b),
        .fault       (fault_b),
        .irq         (irq_b)
    );

    always #5 aclk = ~aclk;

    // edge_n = number of rising edges seen so far.
    int edge_n = 0;
    always @(posedge aclk) edge_n = edge_n + 1;

    typedef struct {
        int         at;
        int         sig;
        logic [3:0] mask;
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [3:0] sample(int sig);
        case (sig)
            0:       return done_a;
            1:       return rst_a;
            2:       return fault_a;
            3:       return {3'b000, irq_a};
            4:       return {3'b000, done_b};
            5:       return {3'b000, rst_b};
            6:       return {3'b000, fault_b};
            default: return {3'b000, irq_b};
        endcase
    endfunction

    // Monitor: compares every queued expectation due at the current edge.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            while (sb.size() > 0 && sb[0].at <= edge_n) begin
                exp_t       e;
                logic [3:0] act;
                e   = sb.pop_front();
                act = sample(e.sig);
                checks++;
                if (e.at != edge_n || ((act ^ e.exp) & e.mask) != 4'b0000) begin
                    errors++;
                    $display("FAIL %s @edge %0d (due %0d): got %b expected %b",
                             e.name, edge_n, e.at, act & e.mask, e.exp & e.mask);
                end
            end
        end
    end

    task automatic push(int at, int sig, logic [3:0] mask, logic [3:0] exp, string name);
        exp_t e;
        e.at = at; e.sig = sig; e.mask = mask; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic exp_a(int at, logic [3:0] d, logic [3:0] r, logic [3:0] f, logic i, string name);
        push(at, 0, 4'b1111, d, {name, "/done"});
        push(at, 1, 4'b1111, r, {name, "/rst_enclave"});
        push(at, 2, 4'b1111, f, {name, "/fault"});
        push(at, 3, 4'b0001, {3'b000, i}, {name, "/irq"});
    endtask

    task automatic exp_b(int at, logic d, logic r, logic f, logic i, string name);
        push(at, 4, 4'b0001, {3'b000, d}, {name, "/done"});
        push(at, 5, 4'b0001, {3'b000, r}, {name, "/rst_enclave"});
        push(at, 6, 4'b0001, {3'b000, f}, {name, "/fault"});
        push(at, 7, 4'b0001, {3'b000, i}, {name, "/irq"});
    endtask

    // Returns on the falling edge just before rising edge k, so inputs set
    // afterwards are the ones sampled at edge k.
    task automatic at_edge(int k);
        while (edge_n < k - 1) @(negedge aclk);
    endtask

    initial begin
        nreset      = 1'b0;
        strt_a      = '0;
        done_cpy_a  = '0;
        fault_clr_a = '0;
        strt_b      = '0;
        done_cpy_b  = '0;
        fault_clr_b = '0;

        // Reset held for edges 1..3 with random channel inputs.
        for (int k = 1; k <= 3; k++) begin
            at_edge(k);
            strt_a      = 4'($urandom);
            done_cpy_a  = 4'($urandom);
            fault_clr_a = 4'($urandom);
        end
        exp_a(3, 4'b0000, 4'b1111, 4'b0000, 1'b0, "reset");
        exp_b(3, 1'b0, 1'b1, 1'b0, 1'b0, "b_reset");

        at_edge(4);
        nreset      = 1'b1;
        strt_a      = '0;
        done_cpy_a  = '0;
        fault_clr_a = '0;
        exp_a(4, 4'b0000, 4'b1111, 4'b0000, 1'b0, "idle");

        // Normal copy on channel 1.
        at_edge(10);
        strt_a = 4'b0010;
        exp_a(13, 4'b0000, 4'b1111, 4'b0000, 1'b0, "copy_wait");
        at_edge(14);
        done_cpy_a = 4'b0010;
        exp_a(14, 4'b0010, 4'b1101, 4'b0000, 1'b0, "copy_done");
        at_edge(15);
        done_cpy_a = 4'b0000;
        exp_a(19, 4'b0010, 4'b1101, 4'b0000, 1'b0, "run_hold");
        at_edge(20);
        strt_a = 4'b0000;
        exp_a(20, 4'b0000, 4'b1111, 4'b0000, 1'b0, "run_exit");

        // Watchdog expiry on channel 2: COPY entered at edge 30.
        at_edge(30);
        strt_a = 4'b0100;
        exp_a(37, 4'b0000, 4'b1111, 4'b0000, 1'b0, "wd_pre");
        exp_a(38, 4'b0000, 4'b1111, 4'b0100, 1'b0, "wd_fault");
        exp_a(39, 4'b0000, 4'b1111, 4'b0100, 1'b1, "wd_irq");
        at_edge(41);
        strt_a      = 4'b0000;
        fault_clr_a = 4'b0100;
        exp_a(41, 4'b0000, 4'b1111, 4'b0000, 1'b1, "wd_clr");
        at_edge(42);
        fault_clr_a = 4'b0000;
        exp_a(42, 4'b0000, 4'b1111, 4'b0000, 1'b0, "wd_irq_off");

        // Completion on the very last watchdog edge wins (COPY at 50, done at 58).
        at_edge(50);
        strt_a = 4'b0100;
        exp_a(57, 4'b0000, 4'b1111, 4'b0000, 1'b0, "wd_last_pre");
        at_edge(58);
        done_cpy_a = 4'b0100;
        exp_a(58, 4'b0100, 4'b1011, 4'b0000, 1'b0, "wd_last_done");
        at_edge(59);
        done_cpy_a = 4'b0000;
        exp_a(59, 4'b0100, 4'b1011, 4'b0000, 1'b0, "wd_no_fault");
        at_edge(62);
        strt_a = 4'b0000;
        exp_a(62, 4'b0000, 4'b1111, 4'b0000, 1'b0, "wd_run_exit");

        // Unsolicited completion on channel 0, clear blocked while requesting.
        at_edge(70);
        done_cpy_a = 4'b0001;
        exp_a(70, 4'b0000, 4'b1111, 4'b0001, 1'b0, "unsol");
        at_edge(71);
        done_cpy_a = 4'b0000;
        exp_a(71, 4'b0000, 4'b1111, 4'b0001, 1'b1, "unsol_irq");
        at_edge(73);
        strt_a      = 4'b0001;
        fault_clr_a = 4'b0001;
        exp_a(74, 4'b0000, 4'b1111, 4'b0001, 1'b1, "clr_ignored");
        at_edge(75);
        strt_a = 4'b0000;
        exp_a(75, 4'b0000, 4'b1111, 4'b0000, 1'b1, "clr");
        at_edge(76);
        fault_clr_a = 4'b0000;
        exp_a(76, 4'b0000, 4'b1111, 4'b0000, 1'b0, "clr_irq_off");

        // Request and completion together in IDLE is a violation.
        at_edge(80);
        strt_a     = 4'b0001;
        done_cpy_a = 4'b0001;
        exp_a(80, 4'b0000, 4'b1111, 4'b0001, 1'b0, "idle_both");
        at_edge(81);
        strt_a      = 4'b0000;
        done_cpy_a  = 4'b0000;
        fault_clr_a = 4'b0001;
        exp_a(81, 4'b0000, 4'b1111, 4'b0000, 1'b1, "idle_both_clr");
        at_edge(82);
        fault_clr_a = 4'b0000;
        exp_a(82, 4'b0000, 4'b1111, 4'b0000, 1'b0, "idle_both_irq_off");

        // Abort on channel 3 after 3 cycles in COPY; watchdog must not fire later.
        at_edge(90);
        strt_a = 4'b1000;
        exp_a(92, 4'b0000, 4'b1111, 4'b0000, 1'b0, "abort_copy");
        at_edge(93);
        strt_a = 4'b0000;
        exp_a(93, 4'b0000, 4'b1111, 4'b0000, 1'b0, "abort_idle");
        exp_a(99, 4'b0000, 4'b1111, 4'b0000, 1'b0, "abort_no_wd");

        // Completion and abort on the same edge: one cycle of RUN.
        at_edge(100);
        strt_a = 4'b1000;
        exp_a(102, 4'b0000, 4'b1111, 4'b0000, 1'b0, "sim_copy");
        at_edge(103);
        strt_a     = 4'b0000;
        done_cpy_a = 4'b1000;
        exp_a(103, 4'b1000, 4'b0111, 4'b0000, 1'b0, "sim_run");
        at_edge(104);
        done_cpy_a = 4'b0000;
        exp_a(104, 4'b0000, 4'b1111, 4'b0000, 1'b0, "sim_exit");

        // Channels 0/1 to RUN, 2/3 to FAULT, then a single reset edge.
        at_edge(110);
        strt_a     = 4'b0011;
        done_cpy_a = 4'b1100;
        at_edge(111);
        done_cpy_a = 4'b0011;
        exp_a(111, 4'b0011, 4'b1100, 4'b1100, 1'b1, "mix");
        at_edge(112);
        done_cpy_a = 4'b0000;
        nreset     = 1'b0;
        exp_a(112, 4'b0000, 4'b1111, 4'b0000, 1'b0, "mid_reset");
        at_edge(113);
        nreset = 1'b1;
        exp_a(113, 4'b0000, 4'b1111, 4'b0000, 1'b0, "post_reset");
        at_edge(114);
        strt_a = 4'b0000;

        // Watchdog disabled: 5000 cycles in COPY without a fault.
        at_edge(120);
        strt_b = 1'b1;
        exp_b(121, 1'b0, 1'b1, 1'b0, 1'b0, "b_copy");
        exp_b(5119, 1'b0, 1'b1, 1'b0, 1'b0, "b_no_wd");
        at_edge(5120);
        done_cpy_b = 1'b1;
        exp_b(5120, 1'b1, 1'b0, 1'b0, 1'b0, "b_run");
        at_edge(5121);
        done_cpy_b = 1'b0;
        strt_b     = 1'b0;
        exp_b(5121, 1'b0, 1'b1, 1'b0, 1'b0, "b_exit");

        at_edge(5125);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enclave_monitor_array.md
# enclave_monitor_array

Parametrised, multi-channel security monitor gating the reset of NUM_ENCL enclaves. Each channel tracks an image-copy handshake (strt_cpy/done_cpy) with its own FSM, releases the enclave reset only after a completed copy, and adds a copy watchdog and protocol-violation detection with sticky fault and interrupt reporting. It sits between the copy DMA/control registers and the per-enclave reset inputs.

## Interface
- NUM_ENCL, 4, number of independent enclave channels (1..32)
- CNT_W, 16, width of per-channel watchdog counter
- TIMEOUT, 1000, max cycles in COPY before fault; 0 disables watchdog; must be < 2^CNT_W

- aclk  input  1  clock, all logic on rising edge
- nreset  input  1  reset, synchronous, active-low
- strt_cpy  input  NUM_ENCL  per-channel copy request/session-active level
- done_cpy  input  NUM_ENCL  per-channel copy-complete indication
- fault_clr  input  NUM_ENCL  per-channel fault acknowledge
- done  output  NUM_ENCL  copy complete, enclave running
- rst_enclave  output  NUM_ENCL  enclave reset, active-high
- fault  output  NUM_ENCL  sticky per-channel fault
- irq  output  1  registered OR of fault

## Operation
- Channels fully independent; bit i of every vector belongs to channel i.
- Per-channel states: IDLE, COPY, RUN, FAULT. Outputs decoded from state register only (Moore, registered).
  - IDLE: done=0, rst_enclave=1, fault=0.
  - COPY: done=0, rst_enclave=1, fault=0; watchdog counts.
  - RUN: done=1, rst_enclave=0, fault=0.
  - FAULT: done=0, rst_enclave=1, fault=1.
- Transitions (priority top-down within each state):
  - IDLE: done_cpy=1 -> FAULT (unsolicited completion); strt_cpy=1 -> COPY; else stay.
  - COPY: done_cpy=1 -> RUN; strt_cpy=0 -> IDLE (abort); TIMEOUT!=0 and cnt==TIMEOUT-1 -> FAULT; else stay, cnt+=1.
  - RUN: strt_cpy=0 -> IDLE; done_cpy ignored.
  - FAULT: fault_clr=1 and strt_cpy=0 -> IDLE; otherwise stay (fault_clr with strt_cpy=1 ignored).
- Watchdog: cnt cleared to 0 on every entry to COPY and in all non-COPY states; CNT_W bits, never wraps because FAULT is taken at TIMEOUT-1.
- done_cpy and strt_cpy=0 simultaneously in COPY -> RUN (completion wins); RUN exits to IDLE on the next cycle since strt_cpy=0.
- irq = OR over fault, registered one extra stage; cleared when all faults cleared.

## Timing
- Reset (nreset=0 at a rising edge): all channels IDLE, cnt=0; done=0, rst_enclave=all 1s, fault=0, irq=0 after that edge. Reset mid-COPY/RUN/FAULT returns channel to IDLE unconditionally; re-asserts rst_enclave.
- Input-to-output latency 1 cycle: input sampled at edge k, outputs change after edge k.
- COPY entered at edge e: fault asserts after edge e+TIMEOUT unless done_cpy=1 sampled at any edge e+1..e+TIMEOUT (done_cpy at e+TIMEOUT wins -> RUN).
- done_cpy sampled at edge m in COPY: rst_enclave falls and done rises after edge m.
- irq follows fault by 1 cycle (both assert and deassert).
- strt_cpy and done_cpy both 1 in IDLE at same edge -> FAULT (violation wins).

## Test plan
- Reset: NUM_ENCL=4, hold nreset=0 3 cycles with random inputs -> done=4'b0000, rst_enclave=4'b1111, fault=4'b0000, irq=0.
- Normal copy ch1, TIMEOUT=8: strt_cpy[1]=1 edge 10, done_cpy[1]=1 edge 14 -> done[1]=1, rst_enclave[1]=0 after edge 14; strt_cpy[1]=0 at edge 20 -> done[1]=0, rst_enclave[1]=1 after edge 20; other channels unchanged.
- Watchdog ch2, TIMEOUT=8: strt_cpy[2]=1 edge 10, no done_cpy -> fault[2]=1 after edge 18, irq=1 after edge 19; done_cpy[2]=1 at edge 18 instead -> RUN, no fault.
- Unsolicited done ch0: done_cpy[0]=1 in IDLE -> fault[0]=1; fault_clr[0]=1 with strt_cpy[0]=1 -> stays FAULT; strt_cpy[0]=0, fault_clr[0]=1 -> IDLE, irq=0 one cycle after fault drops.
- Abort and simultaneous: strt_cpy[3] drops in COPY after 3 cycles -> IDLE, rst_enclave[3]=1, no fault; done_cpy[3]=1 and strt_cpy[3]=0 same edge in COPY -> done[3]=1 for exactly 1 cycle.
- Reset mid-operation: all 4 channels in RUN/FAULT, nreset=0 one edge -> all IDLE, rst_enclave=4'b1111, fault=0, irq=0 next cycle; TIMEOUT=0 build: 5000 cycles in COPY -> no fault.
